// File: rtl/elastic_fork_if.sv
// rtl/elastic_fork_if.sv - producer/consumer handshake bundle for elastic_fork
interface elastic_fork_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUTPUT_NUM = 4
);
    logic [DATA_WIDTH-1:0] data_input;
    logic                  valid_input;
    logic                  stop_input;
    logic [DATA_WIDTH-1:0] data_output [OUTPUT_NUM];
    logic                  valid_output [OUTPUT_NUM];
    logic                  stop_output [OUTPUT_NUM];
    logic [OUTPUT_NUM-1:0] output_mask;
    logic                  busy;

    modport master (
        output data_input, valid_input, stop_output, output_mask,
        input  stop_input, data_output, valid_output, busy
    );

    modport slave (
        input  data_input, valid_input, stop_output, output_mask,
        output stop_input, data_output, valid_output, busy
    );
endinterface

// File: rtl/elastic_fork.sv
// rtl/elastic_fork.sv - eager elastic fork broadcasting one token to masked branches
// Optional 2-entry input FIFO selected by ELASTIC_FORK_INPUT_BUFFER_EN.
module elastic_fork #(
    parameter int DATA_WIDTH = 32,
    parameter int OUTPUT_NUM = 4
) (
    input  logic          clk,
    input  logic          reset,
    elastic_fork_if.slave bus
);
    logic [OUTPUT_NUM-1:0] r_sent;
    logic [OUTPUT_NUM-1:0] w_valid;
    logic [OUTPUT_NUM-1:0] w_take;
    logic [OUTPUT_NUM-1:0] w_done;
    logic [OUTPUT_NUM-1:0] w_mask;
    logic [OUTPUT_NUM-1:0] w_stop;
    logic                  w_head_valid;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_all_done;
    logic                  w_pop;

    assign w_mask = bus.output_mask;

    genvar i;
    generate
        for (i = 0; i < OUTPUT_NUM; i++) begin : g_branch
            assign w_stop[i]           = bus.stop_output[i];
            assign w_valid[i]          = w_head_valid & w_mask[i] & ~r_sent[i];
            assign w_take[i]           = w_valid[i] & ~w_stop[i];
            // A branch is satisfied if disabled, already served, or taking it now
            assign w_done[i]           = ~w_mask[i] | r_sent[i] | ~w_stop[i];
            assign bus.valid_output[i] = w_valid[i];
            assign bus.data_output[i]  = w_head_data;
        end
    endgenerate

    assign w_all_done = &w_done;
    assign w_pop      = w_head_valid & w_all_done;
    assign bus.busy   = w_head_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sent <= '0;
        end else if (w_pop) begin
            r_sent <= '0;
        end else begin
            r_sent <= r_sent | w_take;
        end
    end

`ifdef ELASTIC_FORK_INPUT_BUFFER_EN
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic                  r_full;
    logic                  w_push;
    logic [1:0]            w_count_next;

    assign w_push         = bus.valid_input & ~r_full;
    assign bus.stop_input = r_full;
    assign w_head_valid   = (r_count != 2'd0);
    assign w_head_data    = r_mem[r_rptr];

    always_comb begin
        w_count_next = r_count;
        if (w_push & ~w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (~w_push & w_pop) begin
            w_count_next = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.data_input;
        end
    end

    // Full flag is registered from the next count so stop_input has no comb path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_full  <= 1'b0;
        end else begin
            r_wptr  <= r_wptr ^ w_push;
            r_rptr  <= r_rptr ^ w_pop;
            r_count <= w_count_next;
            r_full  <= (w_count_next == 2'd2);
        end
    end
`else
    // Gated by reset so nothing is offered while the fork is being cleared
    assign w_head_valid   = bus.valid_input & ~reset;
    assign w_head_data    = bus.data_input;
    assign bus.stop_input = w_head_valid & ~w_all_done;
`endif
endmodule

// File: tb/tb_elastic_fork.sv
// tb/tb_elastic_fork.sv - directed table-driven bench for elastic_fork
module tb_elastic_fork;
    localparam int DW = 32;
    localparam int ON = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    elastic_fork_if #(.DATA_WIDTH(DW), .OUTPUT_NUM(ON)) bus ();

    elastic_fork #(.DATA_WIDTH(DW), .OUTPUT_NUM(ON)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  mask;
        logic        vin;
        logic [31:0] din;
        logic [3:0]  sout;
        logic [3:0]  vout;
        logic        sin;
        logic        busy;
        logic [31:0] data;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] mask, input logic vin, input logic [31:0] din,
                         input logic [3:0] sout);
        bus.output_mask = mask;
        bus.valid_input = vin;
        bus.data_input  = din;
        for (int i = 0; i < ON; i++) bus.stop_output[i] = sout[i];
    endtask

    function automatic logic [3:0] vout_vec();
        logic [3:0] v;
        for (int i = 0; i < ON; i++) v[i] = bus.valid_output[i];
        return v;
    endfunction

    task automatic step(input string name, input vec_t v);
        drive(v.mask, v.vin, v.din, v.sout);
        #4;
        check({name, "_vout"}, {28'd0, vout_vec()}, {28'd0, v.vout});
        check({name, "_stop_in"}, {31'd0, bus.stop_input}, {31'd0, v.sin});
        check({name, "_busy"}, {31'd0, bus.busy}, {31'd0, v.busy});
        if (v.vout != 4'd0) begin
            for (int i = 0; i < ON; i++)
                check($sformatf("%s_data%0d", name, i), bus.data_output[i], v.data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_in_reset(input string name);
        #1;
        check({name, "_vout"}, {28'd0, vout_vec()}, 32'd0);
        check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_stop_in"}, {31'd0, bus.stop_input}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(4'hF, 1'b1, 32'h99, 4'h0);
        @(negedge clk);
        check_in_reset("reset");
        drive(4'hF, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        reset = 1'b0;

`ifdef ELASTIC_FORK_INPUT_BUFFER_EN
        // back-to-back full throughput, one cycle latency
        tv.push_back('{4'hF, 1'b1, 32'h11, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        tv.push_back('{4'hF, 1'b1, 32'h22, 4'h0, 4'hF, 1'b0, 1'b1, 32'h11});
        tv.push_back('{4'hF, 1'b1, 32'h33, 4'h0, 4'hF, 1'b0, 1'b1, 32'h22});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h0, 4'hF, 1'b0, 1'b1, 32'h33});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        // branch 2 stalled 3 cycles on 0xAB, 0xCD follows and fills the FIFO
        tv.push_back('{4'hF, 1'b1, 32'hAB, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        tv.push_back('{4'hF, 1'b1, 32'hCD, 4'h4, 4'hF, 1'b0, 1'b1, 32'hAB});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h4, 4'h4, 1'b1, 1'b1, 32'hAB});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h4, 4'h4, 1'b1, 1'b1, 32'hAB});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h0, 4'h4, 1'b1, 1'b1, 32'hAB});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h0, 4'hF, 1'b0, 1'b1, 32'hCD});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        // partial mask; disabled branches stalled must not matter
        tv.push_back('{4'h5, 1'b1, 32'h5A, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        tv.push_back('{4'h5, 1'b0, 32'h0,  4'hA, 4'h5, 1'b0, 1'b1, 32'h5A});
        tv.push_back('{4'h5, 1'b0, 32'h0,  4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        // empty mask drains 1 per cycle
        for (int k = 0; k < 5; k++)
            tv.push_back('{4'h0, 1'b1, 32'(k), 4'hF, 4'h0, 1'b0, (k != 0), 32'h0});
        tv.push_back('{4'h0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0, 1'b1, 32'h0});
        tv.push_back('{4'h0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0, 32'h0});
        // all branches stalled: two accepted, third held by stop_input
        tv.push_back('{4'hF, 1'b1, 32'h01, 4'hF, 4'h0, 1'b0, 1'b0, 32'h0});
        tv.push_back('{4'hF, 1'b1, 32'h02, 4'hF, 4'hF, 1'b0, 1'b1, 32'h01});
        tv.push_back('{4'hF, 1'b1, 32'h03, 4'hF, 4'hF, 1'b1, 1'b1, 32'h01});
        tv.push_back('{4'hF, 1'b1, 32'h03, 4'h0, 4'hF, 1'b1, 1'b1, 32'h01});
        tv.push_back('{4'hF, 1'b1, 32'h03, 4'h0, 4'hF, 1'b0, 1'b1, 32'h02});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h0, 4'hF, 1'b0, 1'b1, 32'h03});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
`else
        tv.push_back('{4'hF, 1'b1, 32'h11, 4'h0, 4'hF, 1'b0, 1'b1, 32'h11});
        tv.push_back('{4'hF, 1'b1, 32'h22, 4'h0, 4'hF, 1'b0, 1'b1, 32'h22});
        tv.push_back('{4'hF, 1'b1, 32'h33, 4'h0, 4'hF, 1'b0, 1'b1, 32'h33});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        // branch 2 stalled 3 cycles; pop in the cycle its stop falls
        tv.push_back('{4'hF, 1'b1, 32'hAB, 4'h4, 4'hF, 1'b1, 1'b1, 32'hAB});
        tv.push_back('{4'hF, 1'b1, 32'hAB, 4'h4, 4'h4, 1'b1, 1'b1, 32'hAB});
        tv.push_back('{4'hF, 1'b1, 32'hAB, 4'h4, 4'h4, 1'b1, 1'b1, 32'hAB});
        tv.push_back('{4'hF, 1'b1, 32'hAB, 4'h0, 4'h4, 1'b0, 1'b1, 32'hAB});
        tv.push_back('{4'hF, 1'b0, 32'h0,  4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        tv.push_back('{4'h5, 1'b1, 32'h5A, 4'hA, 4'h5, 1'b0, 1'b1, 32'h5A});
        tv.push_back('{4'h5, 1'b0, 32'h0,  4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        for (int k = 0; k < 5; k++)
            tv.push_back('{4'h0, 1'b1, 32'(k), 4'hF, 4'h0, 1'b0, 1'b1, 32'h0});
        tv.push_back('{4'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
`endif
        for (int n = 0; n < tv.size(); n++)
            step($sformatf("vec%0d", n), tv[n]);

        // reset while branch 2 is stalled on 0x77
`ifdef ELASTIC_FORK_INPUT_BUFFER_EN
        step("rst_a", '{4'hF, 1'b1, 32'h77, 4'h4, 4'h0, 1'b0, 1'b0, 32'h0});
        step("rst_b", '{4'hF, 1'b0, 32'h0,  4'h4, 4'hF, 1'b0, 1'b1, 32'h77});
        drive(4'hF, 1'b0, 32'h0, 4'h4);
        reset = 1'b1;
        check_in_reset("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        step("rst_c", '{4'hF, 1'b1, 32'h88, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
        step("rst_d", '{4'hF, 1'b0, 32'h0,  4'h0, 4'hF, 1'b0, 1'b1, 32'h88});
        step("rst_e", '{4'hF, 1'b0, 32'h0,  4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
`else
        step("rst_a", '{4'hF, 1'b1, 32'h77, 4'h4, 4'hF, 1'b1, 1'b1, 32'h77});
        step("rst_b", '{4'hF, 1'b1, 32'h77, 4'h4, 4'h4, 1'b1, 1'b1, 32'h77});
        reset = 1'b1;
        check_in_reset("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        step("rst_c", '{4'hF, 1'b1, 32'h88, 4'h0, 4'hF, 1'b0, 1'b1, 32'h88});
        step("rst_d", '{4'hF, 1'b0, 32'h0,  4'h0, 4'h0, 1'b0, 1'b0, 32'h0});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/elastic_fork.md
Name: elastic_fork

Overview:
- One-to-many counterpart of the elastic multiplexer: broadcasts each token from one valid/stop elastic input to a configurable subset of OUTPUT_NUM elastic outputs.
- Eager fork: each enabled output accepts the token independently. The token retires only after every enabled output has taken it.
- Sits at PE output ports and in the interconnect, wherever one producer feeds several consumers.

Parameters:
- DATA_WIDTH, 32, token data width in bits.
- OUTPUT_NUM, 4, number of output branches (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_input  input  DATA_WIDTH  incoming token data.
- valid_input  input  1  incoming token valid.
- stop_input  output  1  backpressure to producer; high = do not present a new token.
- data_output  output  DATA_WIDTH x OUTPUT_NUM (unpacked array)  broadcast data, identical on all branches.
- valid_output  output  1 x OUTPUT_NUM (unpacked array)  per-branch valid.
- stop_output  input  1 x OUTPUT_NUM (unpacked array)  per-branch backpressure from consumers.
- output_mask  input  OUTPUT_NUM  configuration; bit i=1 enables branch i.
- busy  output  1  high while a head token is pending.

Behaviour:
- Protocol: a transfer occurs on a link in a cycle where valid=1 and stop=0.
- Head token (head_valid, head_data) comes from the input stage (direct or buffered, see Optional Feature).
- Per-branch register sent[i]; reset value 0.
- valid_output[i] = head_valid & output_mask[i] & ~sent[i].
- data_output[i] = head_data for all i.
- take[i] = valid_output[i] & ~stop_output[i].
- done[i] = ~output_mask[i] | sent[i] | ~stop_output[i].
- all_done = AND of done[]. Token retires (pop) when head_valid & all_done.
- Register update:
  - On pop: all sent[i] <= 0.
  - Otherwise: sent[i] <= sent[i] | take[i].
- A branch never sees the same token twice. Branches that are not stalled receive it in the first cycle; stalled branches receive it later.
- output_mask = 0: each head token is dropped in the cycle it reaches the head; no valid_output is ever raised.
- output_mask is static configuration. It may change only when busy=0; behaviour is undefined if it changes while a token is pending.
- busy = head_valid.
- Reset values: all valid_output 0, busy 0, sent 0, buffer empty. With the buffer, stop_input is 0. Without it, stop_input follows its combinational equation.
- Reset mid-operation: a pending or buffered token is discarded and sent flags are cleared. The first token after reset is delivered to all enabled branches.

Optional Feature:
- Macro: ELASTIC_FORK_INPUT_BUFFER_EN.
- Defined:
  - 2-entry elastic FIFO (1-bit read/write pointers, 2-bit count) between input and head.
  - Push when valid_input & ~stop_input. stop_input = (count==2), registered.
  - head_valid = (count!=0); head_data = entry at the read pointer.
  - Push and pop in the same cycle leave count unchanged.
  - Latency: 1 cycle from input transfer to valid_output.
  - Full throughput: 1 token/cycle when no branch stalls.
- Undefined:
  - head_valid = valid_input, head_data = data_input, latency 0.
  - stop_input = valid_input & ~all_done (combinational from stop_output).

Test Plan:
- Mask 4'b1111, stop_output all 0, send 0x11, 0x22, 0x33 back-to-back: every branch sees 0x11, 0x22, 0x33 on consecutive cycles; stop_input stays 0; +1 cycle latency with buffer.
- Mask 4'b1111, stop_output[2]=1 for 3 cycles, send 0xAB: branches 0, 1, 3 are valid for exactly 1 cycle; branch 2 is valid for 4 cycles; pop occurs in the cycle stop_output[2] falls; with buffer, a following token 0xCD is accepted and stop_input rises only when count reaches 2.
- Mask 4'b0101, send 0x5A with stop_output all 0: valid_output[1] and [3] are never high; branches 0 and 2 receive 0x5A once; busy clears the next cycle.
- Mask 4'b0000, send 5 tokens: all are drained at 1 per cycle; no valid_output ever; stop_input never high.
- Buffer build only: all stop_output=1, mask 4'b1111, send 0x01, 0x02, 0x03: the first two are accepted, then stop_input=1 holds 0x03; release stalls → all branches get 0x01, 0x02, 0x03 in order, with no loss or duplication.
- Branch 2 stalled on 0x77, assert reset for 1 cycle: all valid_output go 0 immediately and busy=0; after release, send 0x88 → all 4 branches receive 0x88 exactly once.
